riscv_v_pipe_ctrl: RTL and testbench

Valid/ready sequencer for an N-deep vector datapath built from flop-stage instances that have per-stage enable and flush inputs. It tracks per-stage occupancy, generates each stage's `en` (bubble-collapsing backpressure) and `flush`, and applies a global stall. After a flush it holds the input closed for a programmable number of cycles. It sits between the vector issue logic (upstream) and writeback/lane consumer (downstream).

---
 rtl/riscv_v_pkg.sv | 11 +
 rtl/riscv_v_sat_counter.sv | 23 ++
 rtl/riscv_v_pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_riscv_v_pipe_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector pipeline controller.
package riscv_v_pkg;

   typedef enum logic {
      PC_RUN  = 1'b0,
      PC_HOLD = 1'b1
   } pipe_ctrl_state_t;

   localparam int RISCV_V_PERF_CNT_W = 32;

endpackage

// File: rtl/riscv_v_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module riscv_v_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) cnt_d = '0;
      else if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) cnt_q <= cnt_d;

   assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_v_pipe_ctrl.sv
// Valid/ready sequencer for an N-stage vector datapath: occupancy, bubble-collapsing
// enables, flush with post-flush lockout. Optional perf counters: RISCV_V_PIPE_CTRL_PERF_EN.
module riscv_v_pipe_ctrl
   import riscv_v_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int FLUSH_HOLD = 2,
   localparam int OCC_W = $clog2(NUM_STAGES + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   input  logic                  stall_req_i,
   input  logic                  flush_req_i,
   output logic [NUM_STAGES-1:0] stage_en_o,
   output logic [NUM_STAGES-1:0] stage_flush_o,
   output logic [NUM_STAGES-1:0] stage_valid_o,
   output logic [OCC_W-1:0]      occupancy_o
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
   ,
   output logic [RISCV_V_PERF_CNT_W-1:0] perf_stall_cycles_o,
   output logic [RISCV_V_PERF_CNT_W-1:0] perf_xfer_count_o
`endif
);

   localparam int HC_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;

   pipe_ctrl_state_t      state_q, state_d;
   logic [HC_W-1:0]       hc_q, hc_d;
   logic [NUM_STAGES-1:0] valid_q, valid_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [NUM_STAGES-1:0] adv;
   logic                  go, in_xfer, out_xfer;

   // A stage may advance if it or any stage downstream of it is empty.
   always_comb begin
      for (int i = 0; i < NUM_STAGES; i++) begin
         adv[i] = out_ready_i;
         for (int j = i; j < NUM_STAGES; j++)
            if (!valid_q[j]) adv[i] = 1'b1;
      end
   end

   assign go            = !stall_req_i && (state_q == PC_RUN) && !flush_req_i && !rst_i;
   assign stage_en_o    = adv & {NUM_STAGES{go}};
   assign stage_flush_o = {NUM_STAGES{flush_req_i & !rst_i}};
   assign in_ready_o    = adv[0] & go;
   assign out_valid_o   = valid_q[NUM_STAGES-1] & go;
   assign stage_valid_o = rst_i ? '0 : valid_q;
   assign occupancy_o   = rst_i ? '0 : occ_q;
   assign in_xfer       = in_valid_i & in_ready_o;
   assign out_xfer      = out_valid_o & out_ready_i;

   always_comb begin
      valid_d = valid_q;
      occ_d   = occ_q;
      if (flush_req_i) begin
         valid_d = '0;
         occ_d   = '0;
      end else begin
         if (stage_en_o[0]) valid_d[0] = in_xfer;
         for (int i = 1; i < NUM_STAGES; i++)
            if (stage_en_o[i]) valid_d[i] = valid_q[i-1];
         case ({in_xfer, out_xfer})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      if (flush_req_i) begin
         if (FLUSH_HOLD > 0) begin
            state_d = PC_HOLD;
            hc_d    = HC_W'(FLUSH_HOLD);
         end
      end else if (state_q == PC_HOLD) begin
         hc_d = hc_q - HC_W'(1);
         if (hc_q == HC_W'(1)) state_d = PC_RUN;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= PC_RUN;
         hc_q    <= '0;
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         hc_q    <= hc_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

`ifdef RISCV_V_PIPE_CTRL_PERF_EN
   logic stall_evt;
   assign stall_evt = (valid_q[NUM_STAGES-1] & !out_ready_i) | (stall_req_i & |valid_q);

   riscv_v_sat_counter #(.W(RISCV_V_PERF_CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (stall_evt),
      .cnt_o (perf_stall_cycles_o)
   );

   riscv_v_sat_counter #(.W(RISCV_V_PERF_CNT_W)) u_xfer_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .inc_i (out_xfer),
      .cnt_o (perf_xfer_count_o)
   );
`endif

endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// Self-checking bench: directed vector table, hand sequences, and randomized run
// against a behavioural model, on a 3-stage/hold-2 and a 1-stage/hold-0 instance.
module tb_riscv_v_pipe_ctrl;

   logic clk = 1'b0;
   logic rst, iv, orr, st, fl;
   int   pass_cnt = 0, chk_cnt = 0;

   logic       ir0, ov0, ir1, ov1;
   logic [2:0] en0, sf0, sv0;
   logic [1:0] occ0;
   logic [0:0] en1, sf1, sv1, occ1;
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
   logic [31:0] psc0, pxc0, psc1, pxc1;
`endif

   always #5 clk = ~clk;

   riscv_v_pipe_ctrl #(.NUM_STAGES(3), .FLUSH_HOLD(2)) dut0 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(ir0), .out_valid_o(ov0),
      .out_ready_i(orr), .stall_req_i(st), .flush_req_i(fl), .stage_en_o(en0),
      .stage_flush_o(sf0), .stage_valid_o(sv0), .occupancy_o(occ0)
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
      , .perf_stall_cycles_o(psc0), .perf_xfer_count_o(pxc0)
`endif
   );

   riscv_v_pipe_ctrl #(.NUM_STAGES(1), .FLUSH_HOLD(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(ir1), .out_valid_o(ov1),
      .out_ready_i(orr), .stall_req_i(st), .flush_req_i(fl), .stage_en_o(en1),
      .stage_flush_o(sf1), .stage_valid_o(sv1), .occupancy_o(occ1)
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
      , .perf_stall_cycles_o(psc1), .perf_xfer_count_o(pxc1)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc(input logic r, input logic a, input logic b, input logic c, input logic d);
      @(negedge clk);
      rst = r; iv = a; orr = b; st = c; fl = d;
      #1;
   endtask

   // Behavioural model: a set of occupied slots plus a lockout countdown.
   typedef struct {
      logic [3:0] v;
      int         lock;
      longint     st_c, xf_c;
   } ms_t;

   function automatic logic [3:0] m_en(ms_t s, int n, logic o, logic stl, logic f);
      logic [3:0] e = '0;
      logic free;
      for (int i = 0; i < n; i++) begin
         free = o;
         for (int j = i; j < n; j++) if (!s.v[j]) free = 1'b1;
         e[i] = free & !stl & (s.lock == 0) & !f;
      end
      return e;
   endfunction

   // Packed expectation: {ir, ov, en[3:0], sf[3:0], sv[3:0], occ[1:0]}
   function automatic logic [15:0] m_out(ms_t s, int n, logic r, logic o, logic stl, logic f);
      logic [3:0] e, sfl, msk;
      logic ov;
      if (r) return '0;
      msk = 4'((1 << n) - 1);
      e   = m_en(s, n, o, stl, f);
      sfl = f ? msk : 4'b0;
      ov  = s.v[n-1] & !stl & (s.lock == 0) & !f;
      return {e[0], ov, e, sfl, s.v & msk, 2'($countones(s.v & msk))};
   endfunction

   function automatic ms_t m_step(ms_t s, int n, int fh, logic r, logic a, logic o,
                                  logic stl, logic f);
      ms_t ns = s;
      logic [3:0] e;
      logic ov;
      if (r) begin
         ns.v = '0; ns.lock = 0; ns.st_c = 0; ns.xf_c = 0;
         return ns;
      end
      e  = m_en(s, n, o, stl, f);
      ov = s.v[n-1] & !stl & (s.lock == 0) & !f;
      if ((s.v[n-1] & !o) | (stl & (s.v != 0))) ns.st_c++;
      if (ov & o) ns.xf_c++;
      if (f) begin
         ns.v = '0; ns.lock = fh;
      end else begin
         for (int i = 0; i < n; i++)
            if (e[i]) begin
               if (i == 0) ns.v[0] = a & e[0];
               else ns.v[i] = s.v[i-1];
            end
         if (ns.lock > 0) ns.lock--;
      end
      return ns;
   endfunction

   function automatic logic [15:0] act0();
      return {ir0, ov0, 1'b0, en0, 1'b0, sf0, 1'b0, sv0, occ0};
   endfunction
   function automatic logic [15:0] act1();
      return {ir1, ov1, 3'b0, en1, 3'b0, sf1, 3'b0, sv1, 1'b0, occ1};
   endfunction

   typedef struct {
      logic iv, orr, st, fl;
      logic ir, ov;
      logic [2:0] en, sf, sv;
      logic [1:0] occ;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(logic a, logic b, logic c, logic d, logic e, logic g,
                               logic [2:0] h, logic [2:0] k, logic [2:0] m, logic [1:0] p);
      vec_t t;
      t.iv = a; t.orr = b; t.st = c; t.fl = d; t.ir = e; t.ov = g;
      t.en = h; t.sf = k; t.sv = m; t.occ = p;
      return t;
   endfunction

   initial begin
      ms_t m0, m1;
      int  edges, xf;

      //           iv orr st fl  ir ov  en      sf      sv      occ
      tbl[0]  = mk(1, 1, 0, 0,  1, 0, 3'b111, 3'b000, 3'b000, 2'd0);
      tbl[1]  = mk(1, 1, 0, 0,  1, 0, 3'b111, 3'b000, 3'b001, 2'd1);
      tbl[2]  = mk(1, 1, 0, 0,  1, 0, 3'b111, 3'b000, 3'b011, 2'd2);
      tbl[3]  = mk(0, 0, 0, 0,  0, 1, 3'b000, 3'b000, 3'b111, 2'd3);
      tbl[4]  = mk(1, 0, 0, 0,  0, 1, 3'b000, 3'b000, 3'b111, 2'd3);
      tbl[5]  = mk(1, 1, 0, 0,  1, 1, 3'b111, 3'b000, 3'b111, 2'd3);
      tbl[6]  = mk(0, 1, 0, 0,  1, 1, 3'b111, 3'b000, 3'b111, 2'd3);
      tbl[7]  = mk(0, 0, 0, 0,  1, 1, 3'b001, 3'b000, 3'b110, 2'd2);
      tbl[8]  = mk(0, 1, 0, 0,  1, 1, 3'b111, 3'b000, 3'b110, 2'd2);
      tbl[9]  = mk(1, 0, 0, 1,  0, 0, 3'b000, 3'b111, 3'b100, 2'd1);
      tbl[10] = mk(1, 1, 0, 0,  0, 0, 3'b000, 3'b000, 3'b000, 2'd0);
      tbl[11] = mk(1, 1, 0, 1,  0, 0, 3'b000, 3'b111, 3'b000, 2'd0);
      tbl[12] = mk(1, 1, 0, 0,  0, 0, 3'b000, 3'b000, 3'b000, 2'd0);
      tbl[13] = mk(1, 1, 0, 0,  0, 0, 3'b000, 3'b000, 3'b000, 2'd0);
      tbl[14] = mk(1, 1, 0, 0,  1, 0, 3'b111, 3'b000, 3'b000, 2'd0);
      tbl[15] = mk(1, 1, 1, 0,  0, 0, 3'b000, 3'b000, 3'b001, 2'd1);
      tbl[16] = mk(1, 1, 1, 0,  0, 0, 3'b000, 3'b000, 3'b001, 2'd1);
      tbl[17] = mk(0, 1, 0, 0,  1, 0, 3'b111, 3'b000, 3'b001, 2'd1);

      // Reset with every input asserted: all outputs held low.
      cyc(1, 1, 1, 1, 1);
      check("reset0", 32'(act0()), 32'h0);
      check("reset1", 32'(act1()), 32'h0);
      cyc(1, 1, 1, 1, 1);
      check("reset0b", 32'(act0()), 32'h0);

      for (int k = 0; k < 18; k++) begin
         cyc(0, tbl[k].iv, tbl[k].orr, tbl[k].st, tbl[k].fl);
         check($sformatf("tbl[%0d]", k),
               32'({ir0, ov0, en0, sf0, sv0, occ0}),
               32'({tbl[k].ir, tbl[k].ov, tbl[k].en, tbl[k].sf, tbl[k].sv, tbl[k].occ}));
      end

      // Latency: a lone word appears at the output three edges after acceptance.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      check("lat_accept", 32'(ir0), 32'd1);
      cyc(0, 0, 1, 0, 0);
      edges = 1;
      while (!ov0 && edges < 10) begin
         cyc(0, 0, 1, 0, 0);
         edges++;
      end
      check("latency", 32'(edges), 32'd3);

      // Stall mid-stream: nothing moves, nothing emitted, nothing lost.
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 1, 1, 0);
         check($sformatf("stall_hold[%0d]", k), 32'({ov0, ir0, sv0}), 32'({2'b00, 3'b111}));
      end
      xf = 0;
      for (int k = 0; k < 6; k++) begin
         cyc(0, 0, 1, 0, 0);
         if (ov0) xf++;
      end
      check("stall_drain", 32'(xf), 32'd3);
      check("stall_empty", 32'(occ0), 32'd0);

      // Randomized run against the model on both instances.
      m0 = '{v: 4'b0, lock: 0, st_c: 0, xf_c: 0};
      m1 = m0;
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 2000; k++) begin
         cyc(($urandom_range(99) < 2), ($urandom_range(99) < 70), ($urandom_range(99) < 60),
             ($urandom_range(99) < 10), ($urandom_range(99) < 5));
         check("rnd0", 32'(act0()), 32'(m_out(m0, 3, rst, orr, st, fl)));
         check("rnd1", 32'(act1()), 32'(m_out(m1, 1, rst, orr, st, fl)));
         check("occ_bound", 32'(occ0 <= 2'd3 && occ0 == 2'($countones(sv0))), 32'd1);
         m0 = m_step(m0, 3, 2, rst, iv, orr, st, fl);
         m1 = m_step(m1, 1, 0, rst, iv, orr, st, fl);
      end
      cyc(0, 0, 0, 0, 0);
`ifdef RISCV_V_PIPE_CTRL_PERF_EN
      check("perf_stall0", psc0, 32'(m0.st_c));
      check("perf_xfer0", pxc0, 32'(m0.xf_c));
      check("perf_xfer1", pxc1, 32'(m1.xf_c));
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
